// File: rtl/shared_tlb_miss_arbiter_pkg.sv
// shared_tlb_miss_arbiter_pkg: state and requester types shared by the miss arbiter
package shared_tlb_miss_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} arb_state_e;
  typedef enum logic {REQ_ITLB, REQ_DTLB} requester_e;
endpackage

// File: rtl/shared_tlb_miss_arbiter.sv
// shared_tlb_miss_arbiter: round-robin ITLB/DTLB miss arbiter onto one shared walker port
// Ports: itlb/dtlb miss request in (valid/ready/vaddr), walk request out (valid/ready/payload),
// walk completion in (done/err/pte), per-requester response pulses out, busy_o, flush_i, rst_i.
module shared_tlb_miss_arbiter
  import shared_tlb_miss_arbiter_pkg::*;
#(
  parameter int VLEN  = 32,
  parameter int PTE_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             itlb_req_valid_i,
  output logic             itlb_req_ready_o,
  input  logic [VLEN-1:0]  itlb_vaddr_i,
  input  logic             dtlb_req_valid_i,
  output logic             dtlb_req_ready_o,
  input  logic [VLEN-1:0]  dtlb_vaddr_i,
  input  logic             dtlb_is_store_i,
  output logic             walk_req_valid_o,
  input  logic             walk_req_ready_i,
  output logic [VLEN-1:0]  walk_vaddr_o,
  output logic             walk_is_instr_o,
  output logic             walk_is_store_o,
  input  logic             walk_done_i,
  input  logic             walk_err_i,
  input  logic [PTE_W-1:0] walk_pte_i,
  output logic             itlb_rsp_valid_o,
  output logic             dtlb_rsp_valid_o,
  output logic             rsp_err_o,
  output logic [PTE_W-1:0] rsp_pte_o,
  output logic             busy_o
);
  arb_state_e       r_state;
  requester_e       r_rr_last;
  logic             r_drop;
  logic [VLEN-1:0]  r_vaddr;
  logic             r_is_instr;
  logic             r_is_store;
  logic             r_itlb_rsp;
  logic             r_dtlb_rsp;
  logic             r_rsp_err;
  logic [PTE_W-1:0] r_rsp_pte;
  logic             w_open;
  logic             w_grant_i;
  logic             w_grant_d;
  // With both requesters asking, the one that did not win last time goes first.
  assign w_open    = (r_state == IDLE) && !flush_i;
  assign w_grant_i = w_open && itlb_req_valid_i && (!dtlb_req_valid_i || r_rr_last == REQ_DTLB);
  assign w_grant_d = w_open && dtlb_req_valid_i && (!itlb_req_valid_i || r_rr_last == REQ_ITLB);
  assign itlb_req_ready_o = w_grant_i;
  assign dtlb_req_ready_o = w_grant_d;
  assign walk_req_valid_o = r_state == REQ;
  assign walk_vaddr_o     = r_vaddr;
  assign walk_is_instr_o  = r_is_instr;
  assign walk_is_store_o  = r_is_store;
  assign itlb_rsp_valid_o = r_itlb_rsp;
  assign dtlb_rsp_valid_o = r_dtlb_rsp;
  assign rsp_err_o        = r_rsp_err;
  assign rsp_pte_o        = r_rsp_pte;
  assign busy_o           = r_state != IDLE;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_rr_last  <= REQ_DTLB;
      r_drop     <= 1'b0;
      r_vaddr    <= '0;
      r_is_instr <= 1'b0;
      r_is_store <= 1'b0;
      r_itlb_rsp <= 1'b0;
      r_dtlb_rsp <= 1'b0;
      r_rsp_err  <= 1'b0;
      r_rsp_pte  <= '0;
    end else begin
      r_itlb_rsp <= 1'b0;
      r_dtlb_rsp <= 1'b0;
      case (r_state)
        IDLE: if (w_grant_i || w_grant_d) begin
          r_state    <= REQ;
          r_vaddr    <= w_grant_i ? itlb_vaddr_i : dtlb_vaddr_i;
          r_is_instr <= w_grant_i;
          r_is_store <= w_grant_d && dtlb_is_store_i;
          r_rr_last  <= w_grant_i ? REQ_ITLB : REQ_DTLB;
        end
        // A flush racing the walker's accept cannot cancel the walk, so its result is marked stale.
        REQ: if (walk_req_ready_i) begin
          r_state <= WAIT;
          r_drop  <= flush_i;
        end else if (flush_i) begin
          r_state <= IDLE;
        end
        WAIT: if (walk_done_i) begin
          r_rsp_pte  <= walk_pte_i;
          r_rsp_err  <= walk_err_i;
          r_itlb_rsp <= !r_drop && !flush_i && r_is_instr;
          r_dtlb_rsp <= !r_drop && !flush_i && !r_is_instr;
          r_drop     <= 1'b0;
          r_state    <= IDLE;
        end else if (flush_i) begin
          r_drop <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shared_tlb_miss_arbiter.sv
// tb_shared_tlb_miss_arbiter: directed bench with a transaction-level reference model
module tb_shared_tlb_miss_arbiter;
  localparam int VLEN  = 32;
  localparam int PTE_W = 32;
  logic             clk_i = 0;
  logic             rst_i = 1;
  logic             flush_i = 0;
  logic             itlb_req_valid_i = 0;
  logic             itlb_req_ready_o;
  logic [VLEN-1:0]  itlb_vaddr_i = '0;
  logic             dtlb_req_valid_i = 0;
  logic             dtlb_req_ready_o;
  logic [VLEN-1:0]  dtlb_vaddr_i = '0;
  logic             dtlb_is_store_i = 0;
  logic             walk_req_valid_o;
  logic             walk_req_ready_i = 0;
  logic [VLEN-1:0]  walk_vaddr_o;
  logic             walk_is_instr_o;
  logic             walk_is_store_o;
  logic             walk_done_i = 0;
  logic             walk_err_i = 0;
  logic [PTE_W-1:0] walk_pte_i = '0;
  logic             itlb_rsp_valid_o;
  logic             dtlb_rsp_valid_o;
  logic             rsp_err_o;
  logic [PTE_W-1:0] rsp_pte_o;
  logic             busy_o;
  int n_checks = 0;
  int n_fails  = 0;
  shared_tlb_miss_arbiter #(.VLEN(VLEN), .PTE_W(PTE_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .itlb_req_valid_i(itlb_req_valid_i), .itlb_req_ready_o(itlb_req_ready_o), .itlb_vaddr_i(itlb_vaddr_i),
    .dtlb_req_valid_i(dtlb_req_valid_i), .dtlb_req_ready_o(dtlb_req_ready_o), .dtlb_vaddr_i(dtlb_vaddr_i),
    .dtlb_is_store_i(dtlb_is_store_i),
    .walk_req_valid_o(walk_req_valid_o), .walk_req_ready_i(walk_req_ready_i), .walk_vaddr_o(walk_vaddr_o),
    .walk_is_instr_o(walk_is_instr_o), .walk_is_store_o(walk_is_store_o),
    .walk_done_i(walk_done_i), .walk_err_i(walk_err_i), .walk_pte_i(walk_pte_i),
    .itlb_rsp_valid_o(itlb_rsp_valid_o), .dtlb_rsp_valid_o(dtlb_rsp_valid_o),
    .rsp_err_o(rsp_err_o), .rsp_pte_o(rsp_pte_o), .busy_o(busy_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  // Reference model: at most one outstanding walk, held in a queue with its lifecycle flags.
  typedef struct {bit instr; bit sent; bit stale;} walk_t;
  walk_t           q[$];
  bit              m_on = 0;
  bit              m_last_itlb;
  logic [VLEN-1:0] m_vaddr;
  bit              m_instr, m_store, m_rsp_i, m_rsp_d, m_err;
  logic [PTE_W-1:0] m_pte;
  always @(negedge clk_i) begin
    bit gi, gd;
    walk_t w;
    gi = q.size() == 0 && !flush_i && itlb_req_valid_i && (!dtlb_req_valid_i || !m_last_itlb);
    gd = q.size() == 0 && !flush_i && dtlb_req_valid_i && (!itlb_req_valid_i || m_last_itlb);
    if (m_on) begin
      chk("itlb_ready", itlb_req_ready_o, gi);
      chk("dtlb_ready", dtlb_req_ready_o, gd);
      chk("walk_valid", walk_req_valid_o, q.size() == 1 && !q[0].sent);
      chk("walk_vaddr", walk_vaddr_o, m_vaddr);
      chk("walk_instr", walk_is_instr_o, m_instr);
      chk("walk_store", walk_is_store_o, m_store);
      chk("itlb_rsp", itlb_rsp_valid_o, m_rsp_i);
      chk("dtlb_rsp", dtlb_rsp_valid_o, m_rsp_d);
      chk("rsp_err", rsp_err_o, m_err);
      chk("rsp_pte", rsp_pte_o, m_pte);
      chk("busy", busy_o, q.size() != 0);
    end
    if (rst_i) begin
      q.delete();
      m_on = 1; m_last_itlb = 0; m_vaddr = '0; m_instr = 0; m_store = 0;
      m_rsp_i = 0; m_rsp_d = 0; m_err = 0; m_pte = '0;
    end else begin
      m_rsp_i = 0; m_rsp_d = 0;
      if (q.size() == 0) begin
        if (gi || gd) begin
          w.instr = gi; w.sent = 0; w.stale = 0;
          q.push_back(w);
          m_vaddr = gi ? itlb_vaddr_i : dtlb_vaddr_i;
          m_instr = gi;
          m_store = gd && dtlb_is_store_i;
          m_last_itlb = gi;
        end
      end else if (!q[0].sent) begin
        if (walk_req_ready_i) begin
          q[0].sent = 1;
          q[0].stale = flush_i;
        end else if (flush_i) q.delete();
      end else if (walk_done_i) begin
        m_pte = walk_pte_i; m_err = walk_err_i;
        if (!q[0].stale && !flush_i) begin
          m_rsp_i = q[0].instr;
          m_rsp_d = !q[0].instr;
        end
        q.delete();
      end else if (flush_i) q[0].stale = 1;
    end
  end
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk_i);
    #1;
  endtask
  task automatic wait_walk(output bit instr);
    for (int k = 0; k < 20 && !walk_req_valid_o; k++) step(1);
    if (!walk_req_valid_o) chk("walk_timeout", 0, 1);
    instr = walk_is_instr_o;
  endtask
  initial begin
    bit instr;
    bit exp_seq [3] = '{1'b1, 1'b0, 1'b1};
    step(2);
    #1;
    chk("rst_walk_valid", walk_req_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_vaddr", walk_vaddr_o, 0);
    chk("rst_rsp", {itlb_rsp_valid_o, dtlb_rsp_valid_o, rsp_err_o}, 0);
    rst_i = 0;
    step(1);
    // Single DTLB store miss.
    walk_req_ready_i = 1;
    dtlb_req_valid_i = 1; dtlb_vaddr_i = 32'h8000_1000; dtlb_is_store_i = 1;
    #1 chk("t1_grant", dtlb_req_ready_o, 1);
    step(1);
    dtlb_req_valid_i = 0; dtlb_is_store_i = 0;
    #1 chk("t1_walk_vaddr", walk_vaddr_o, 32'h8000_1000);
    chk("t1_walk_store", walk_is_store_o, 1);
    step(5);
    walk_done_i = 1; walk_pte_i = 32'h2000_00CF;
    step(1);
    walk_done_i = 0;
    #1 chk("t1_dtlb_rsp", dtlb_rsp_valid_o, 1);
    chk("t1_itlb_rsp", itlb_rsp_valid_o, 0);
    chk("t1_pte", rsp_pte_o, 32'h2000_00CF);
    step(1);
    // Round-robin from reset with both requesters held.
    rst_i = 1; step(1); rst_i = 0;
    itlb_req_valid_i = 1; itlb_vaddr_i = 32'h0000_4000;
    dtlb_req_valid_i = 1; dtlb_vaddr_i = 32'h0000_9000;
    for (int i = 0; i < 3; i++) begin
      wait_walk(instr);
      chk("t2_rr_instr", instr, exp_seq[i]);
      step(2);
      if (i == 2) begin itlb_req_valid_i = 0; dtlb_req_valid_i = 0; end
      walk_done_i = 1; walk_pte_i = 32'h100 + i;
      step(1);
      walk_done_i = 0;
    end
    step(1);
    // Flush while the walker has not accepted.
    walk_req_ready_i = 0;
    itlb_req_valid_i = 1; itlb_vaddr_i = 32'h0001_2000;
    step(1);
    itlb_req_valid_i = 0;
    #1 chk("t3_req", walk_req_valid_o, 1);
    flush_i = 1;
    step(1);
    flush_i = 0;
    #1 chk("t3_walk_drop", walk_req_valid_o, 0);
    chk("t3_busy", busy_o, 0);
    step(2);
    // Flush during the walk, erroring result discarded.
    walk_req_ready_i = 1;
    dtlb_req_valid_i = 1; dtlb_vaddr_i = 32'h0003_3000;
    step(1);
    dtlb_req_valid_i = 0;
    step(1);
    flush_i = 1; step(1); flush_i = 0;
    step(1);
    walk_done_i = 1; walk_err_i = 1; walk_pte_i = 32'hDEAD_0001;
    step(1);
    walk_done_i = 0; walk_err_i = 0;
    #1 chk("t4_no_rsp", {itlb_rsp_valid_o, dtlb_rsp_valid_o}, 0);
    chk("t4_err", rsp_err_o, 1);
    chk("t4_idle", busy_o, 0);
    itlb_req_valid_i = 1; itlb_vaddr_i = 32'h0004_4000;
    #1 chk("t4_regrant", itlb_req_ready_o, 1);
    step(1);
    itlb_req_valid_i = 0;
    step(1);
    walk_done_i = 1; walk_pte_i = 32'h0004_40CF;
    step(1);
    walk_done_i = 0;
    #1 chk("t4_itlb_rsp", itlb_rsp_valid_o, 1);
    step(1);
    // Reset mid-walk, then a stray completion.
    dtlb_req_valid_i = 1; dtlb_vaddr_i = 32'h0005_5000;
    step(1);
    dtlb_req_valid_i = 0;
    step(1);
    rst_i = 1; step(1); rst_i = 0;
    walk_done_i = 1; walk_pte_i = 32'hFFFF_FFFF; walk_err_i = 1;
    step(1);
    walk_done_i = 0; walk_err_i = 0;
    #1 chk("t5_quiet", {itlb_rsp_valid_o, dtlb_rsp_valid_o, rsp_err_o, walk_req_valid_o, busy_o}, 0);
    chk("t5_pte", rsp_pte_o, 0);
    chk("t5_vaddr", walk_vaddr_o, 0);
    step(1);
    // Completion with a new DTLB request already waiting.
    dtlb_req_valid_i = 1; dtlb_vaddr_i = 32'h0006_6000;
    step(1);
    dtlb_req_valid_i = 0;
    step(1);
    dtlb_req_valid_i = 1; dtlb_vaddr_i = 32'h0007_7000;
    walk_done_i = 1; walk_pte_i = 32'h0006_60CF;
    step(1);
    walk_done_i = 0;
    #1 chk("t6_rsp", dtlb_rsp_valid_o, 1);
    chk("t6_ready", dtlb_req_ready_o, 1);
    chk("t6_pte", rsp_pte_o, 32'h0006_60CF);
    step(1);
    dtlb_req_valid_i = 0;
    #1 chk("t6_vaddr", walk_vaddr_o, 32'h0007_7000);
    step(1);
    walk_done_i = 1; walk_pte_i = 32'h0007_70CF;
    step(1);
    walk_done_i = 0;
    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
